add_share_arb: RTL and testbench

ADD_SHARE_ARB -- requirements
Module: add_share_arb

---
 rtl/add_share_arb.sv | 100 ++++++++++
 tb/tb_add_share_arb.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/add_share_arb.sv
// Four-way round-robin arbiter sharing one 8-bit ripple adder.
// The winner's operand pair is summed and held in a single result register.
module add_share_arb #(
  parameter int SAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [3:0]  req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [1:0]  resp_id,
  output logic [7:0]  resp_sum,
  output logic        resp_ovf
);

  logic [1:0] ptr;
  logic [1:0] gnt_idx;
  logic [1:0] cand;
  logic       gnt_any;
  logic       can_accept;
  logic       accept;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [7:0] raw_sum;
  logic       ovf;
  logic [7:0] out_sum;

  // Scan from the highest offset down so the first valid index after ptr wins.
  always_comb begin
    gnt_idx = ptr;
    gnt_any = 1'b0;
    cand    = ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req_valid[cand]) begin
        gnt_idx = cand;
        gnt_any = 1'b1;
      end
    end
  end

  assign can_accept = !resp_valid || resp_ready;
  assign accept     = gnt_any && can_accept && !rst;
  assign req_ready  = accept ? (4'b0001 << gnt_idx) : 4'b0000;

  assign op_a = req_a[{gnt_idx, 3'b000} +: 8];
  assign op_b = req_b[{gnt_idx, 3'b000} +: 8];

  fadd8 u_fadd8 (
    .a (op_a),
    .b (op_b),
    .s (raw_sum)
  );

  // The adder has no carry port; a wrapped unsigned sum is smaller than either operand.
  assign ovf     = (raw_sum < op_a);
  assign out_sum = ((SAT != 0) && ovf) ? 8'hFF : raw_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= 2'd0;
      resp_valid <= 1'b0;
      resp_id    <= 2'd0;
      resp_sum   <= 8'h00;
      resp_ovf   <= 1'b0;
    end else if (accept) begin
      ptr        <= gnt_idx + 2'd1;
      resp_valid <= 1'b1;
      resp_id    <= gnt_idx;
      resp_sum   <= out_sum;
      resp_ovf   <= ovf;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// Plain 8-bit ripple-carry adder, carry-out discarded.
module fadd8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] s
);

  logic [7:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign s[i] = a[i] ^ b[i] ^ c[i];
    if (i < 7) begin : g_carry
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

endmodule

// File: tb/tb_add_share_arb.sv
// Directed bench for add_share_arb; a wrapping and a saturating instance share stimulus.
module tb_add_share_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_ready;

  logic [3:0]  req_ready0, req_ready1;
  logic        resp_valid0, resp_valid1;
  logic [1:0]  resp_id0, resp_id1;
  logic [7:0]  resp_sum0, resp_sum1;
  logic        resp_ovf0, resp_ovf1;

  int tests;
  int fails;

  add_share_arb #(.SAT(0)) u_wrap (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready0),
    .resp_valid (resp_valid0),
    .resp_ready (resp_ready),
    .resp_id    (resp_id0),
    .resp_sum   (resp_sum0),
    .resp_ovf   (resp_ovf0)
  );

  add_share_arb #(.SAT(1)) u_sat (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready1),
    .resp_valid (resp_valid1),
    .resp_ready (resp_ready),
    .resp_id    (resp_id1),
    .resp_sum   (resp_sum1),
    .resp_ovf   (resp_ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic [3:0] v,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic rr);
    @(negedge clk);
    rst        = r;
    req_valid  = v;
    req_a      = a;
    req_b      = b;
    resp_ready = rr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; req_valid = 4'b0; req_a = 32'h0; req_b = 32'h0; resp_ready = 1'b1;

    // Reset: no grants while rst is high, registers cleared.
    applyStimulus(1'b1, 4'b1111, 32'h04030201, 32'h40302010, 1'b1);
    checkOutput("rst_req_ready", 32'(req_ready0), 32'h0);
    nextEdge();
    checkOutput("rst_resp_valid", 32'(resp_valid0), 32'h0);
    checkOutput("rst_resp_id", 32'(resp_id0), 32'h0);
    checkOutput("rst_resp_sum", 32'(resp_sum0), 32'h0);
    checkOutput("rst_resp_ovf", 32'(resp_ovf0), 32'h0);

    // Single request from requester 2.
    applyStimulus(1'b0, 4'b0100, 32'hAA12BBCC, 32'h55346677, 1'b1);
    checkOutput("single_req_ready", 32'(req_ready0), 32'h4);
    nextEdge();
    checkOutput("single_valid", 32'(resp_valid0), 32'h1);
    checkOutput("single_id", 32'(resp_id0), 32'h2);
    checkOutput("single_sum", 32'(resp_sum0), 32'h46);
    checkOutput("single_ovf", 32'(resp_ovf0), 32'h0);

    // Drain with no new request.
    applyStimulus(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
    checkOutput("idle_req_ready", 32'(req_ready0), 32'h0);
    nextEdge();
    checkOutput("drain_valid", 32'(resp_valid0), 32'h0);

    // Round robin from ptr=0 with all four requesting.
    applyStimulus(1'b1, 4'b0000, 32'h0, 32'h0, 1'b1);
    nextEdge();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'b1111, 32'h04030201, 32'h40302010, 1'b1);
      checkOutput("rr_req_ready", 32'(req_ready0), 32'(4'b0001 << (i % 4)));
      nextEdge();
      checkOutput("rr_valid", 32'(resp_valid0), 32'h1);
      checkOutput("rr_id", 32'(resp_id0), 32'(i % 4));
      checkOutput("rr_sum", 32'(resp_sum0), 32'(((i % 4) + 1) * 8'h11));
    end

    // Overflow cases on requester 0 (ptr is 1, only 0 valid).
    applyStimulus(1'b0, 4'b0001, 32'h000000F0, 32'h00000020, 1'b1);
    checkOutput("ovf1_req_ready", 32'(req_ready0), 32'h1);
    nextEdge();
    checkOutput("ovf1_wrap_sum", 32'(resp_sum0), 32'h10);
    checkOutput("ovf1_wrap_ovf", 32'(resp_ovf0), 32'h1);
    checkOutput("ovf1_sat_sum", 32'(resp_sum1), 32'hFF);
    checkOutput("ovf1_sat_ovf", 32'(resp_ovf1), 32'h1);

    applyStimulus(1'b0, 4'b0001, 32'h00000080, 32'h00000080, 1'b1);
    nextEdge();
    checkOutput("ovf2_wrap_sum", 32'(resp_sum0), 32'h00);
    checkOutput("ovf2_wrap_ovf", 32'(resp_ovf0), 32'h1);
    checkOutput("ovf2_sat_sum", 32'(resp_sum1), 32'hFF);

    applyStimulus(1'b0, 4'b0001, 32'h000000FF, 32'h00000000, 1'b1);
    nextEdge();
    checkOutput("noovf_wrap_sum", 32'(resp_sum0), 32'hFF);
    checkOutput("noovf_wrap_ovf", 32'(resp_ovf0), 32'h0);
    checkOutput("noovf_sat_sum", 32'(resp_sum1), 32'hFF);
    checkOutput("noovf_sat_ovf", 32'(resp_ovf1), 32'h0);

    // Backpressure: result pending, consumer stalls for three cycles.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'b1111, 32'h04030201, 32'h40302010, 1'b0);
      checkOutput("bp_req_ready", 32'(req_ready0), 32'h0);
      nextEdge();
      checkOutput("bp_valid", 32'(resp_valid0), 32'h1);
      checkOutput("bp_id", 32'(resp_id0), 32'h0);
      checkOutput("bp_sum", 32'(resp_sum0), 32'hFF);
      checkOutput("bp_ovf", 32'(resp_ovf0), 32'h0);
    end
    applyStimulus(1'b0, 4'b1111, 32'h04030201, 32'h40302010, 1'b1);
    checkOutput("bp_release_ready", 32'(req_ready0), 32'h2);
    nextEdge();
    checkOutput("bp_release_valid", 32'(resp_valid0), 32'h1);
    checkOutput("bp_release_id", 32'(resp_id0), 32'h1);
    checkOutput("bp_release_sum", 32'(resp_sum0), 32'h22);

    // Reset mid-operation (ptr=2, result pending).
    applyStimulus(1'b1, 4'b1111, 32'h04030201, 32'h40302010, 1'b0);
    checkOutput("midrst_req_ready", 32'(req_ready0), 32'h0);
    nextEdge();
    checkOutput("midrst_valid", 32'(resp_valid0), 32'h0);
    checkOutput("midrst_id", 32'(resp_id0), 32'h0);
    checkOutput("midrst_sum", 32'(resp_sum0), 32'h0);
    checkOutput("midrst_ovf", 32'(resp_ovf0), 32'h0);
    applyStimulus(1'b0, 4'b1111, 32'h04030201, 32'h40302010, 1'b1);
    checkOutput("postrst_req_ready", 32'(req_ready0), 32'h1);
    nextEdge();
    checkOutput("postrst_id", 32'(resp_id0), 32'h0);
    checkOutput("postrst_sum", 32'(resp_sum0), 32'h11);

    // Sparse requesters: pointer must skip idle indices and wrap.
    applyStimulus(1'b0, 4'b1010, 32'h04030201, 32'h40302010, 1'b1);
    checkOutput("skip1_req_ready", 32'(req_ready0), 32'h2);
    nextEdge();
    checkOutput("skip1_sum", 32'(resp_sum0), 32'h22);
    applyStimulus(1'b0, 4'b1010, 32'h04030201, 32'h40302010, 1'b1);
    checkOutput("skip2_req_ready", 32'(req_ready0), 32'h8);
    nextEdge();
    checkOutput("skip2_id", 32'(resp_id0), 32'h3);
    checkOutput("skip2_sum", 32'(resp_sum0), 32'h44);
    applyStimulus(1'b0, 4'b1010, 32'h04030201, 32'h40302010, 1'b1);
    checkOutput("skip3_req_ready", 32'(req_ready0), 32'h2);
    nextEdge();
    checkOutput("skip3_id", 32'(resp_id0), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
